// File: rtl/conv_result_collector_pkg.sv
// Shared constants and types for the convolution kernel array and its result collector.
// KERNEL_LATENCY is also used by the array's clear-delay logic, so keep it defined only here.
package conv_result_collector_pkg;

    localparam int unsigned ARRAY_SIZE     = 6;
    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned KERNEL_LATENCY = 3;
    localparam int unsigned BUS_WIDTH      = ARRAY_SIZE * DATA_WIDTH;
    localparam int unsigned INDEX_WIDTH    = 3;

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } ser_state_e;

    function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] value,
                                                   input logic                  enable);
        return (enable && value[DATA_WIDTH-1]) ? '0 : value;
    endfunction

endpackage

// File: rtl/conv_result_fifo2.sv
// Two-entry full-bus FIFO holding captured kernel windows.
// A push into a full FIFO succeeds only when a pop happens at the same edge.
module conv_result_fifo2
    import conv_result_collector_pkg::*;
#(
    parameter int unsigned WIDTH = BUS_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [1:0]       count,
    output logic             overflow
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       count_q, count_d;
    logic             full, empty, do_push, do_pop;

    assign full     = (count_q == 2'd2);
    assign empty    = (count_q == 2'd0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign overflow = push & full & ~do_pop;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    // When full, the slot being popped is the one being refilled.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/conv_result_collector.sv
// Captures the kernel array accumulator bus at a fixed latency after each window's last tap,
// buffers two windows and serialises each window lane by lane onto a valid/ready stream.
module conv_result_collector
    import conv_result_collector_pkg::*;
#(
    parameter bit RELU_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [BUS_WIDTH-1:0]   i_pixel_bus,
    input  logic                   i_done,
    input  logic                   i_clr_ovf,
    input  logic                   i_ready,
    output logic                   o_valid,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic [INDEX_WIDTH-1:0] o_index,
    output logic                   o_last,
    output logic                   o_busy,
    output logic                   o_overflow
);

    localparam logic [INDEX_WIDTH-1:0] LastIdx = INDEX_WIDTH'(ARRAY_SIZE - 1);

    logic [KERNEL_LATENCY-1:0] done_sr_q;
    logic                      capture;
    logic [BUS_WIDTH-1:0]      head;
    logic [1:0]                fifo_count;
    logic                      fifo_ovf;
    logic                      pop;
    logic                      handshake;
    logic                      last_lane;
    logic [DATA_WIDTH-1:0]     lane_data;
    logic [INDEX_WIDTH-1:0]    index_q, index_d;
    logic                      ovf_q;
    ser_state_e                state_q, state_d;

    // Delay line aligns i_done with the cycle the accumulators become valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_sr_q <= '0;
        end else begin
            done_sr_q <= {done_sr_q[KERNEL_LATENCY-2:0], i_done};
        end
    end

    assign capture   = done_sr_q[KERNEL_LATENCY-1];
    assign last_lane = (index_q == LastIdx);
    assign handshake = o_valid & i_ready;
    assign pop       = handshake & last_lane;

    conv_result_fifo2 #(
        .WIDTH (BUS_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (capture),
        .pop      (pop),
        .wdata    (i_pixel_bus),
        .rdata    (head),
        .count    (fifo_count),
        .overflow (fifo_ovf)
    );

    // Set wins over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (fifo_ovf) begin
            ovf_q <= 1'b1;
        end else if (i_clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    always_comb begin
        index_d = index_q;
        if (handshake) begin
            index_d = last_lane ? '0 : index_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q <= '0;
        end else begin
            index_q <= index_d;
        end
    end

    // Lane 0 sits in the most significant slice of the bus.
    always_comb begin
        lane_data = '0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            if (index_q == INDEX_WIDTH'(i)) begin
                lane_data = head[(ARRAY_SIZE-1-i)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (capture) state_d = StSend;
            end
            StSend: begin
                // Remaining count after the pop, including a capture at the same edge.
                if (pop && fifo_count <= 2'd1 && !capture) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_valid = (state_q == StSend);
        o_data  = o_valid ? relu(lane_data, RELU_EN) : '0;
        o_last  = o_valid & last_lane;
        o_busy  = (fifo_count != 2'd0) | (state_q == StSend);
    end

    assign o_index    = index_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_conv_result_collector.sv
// Directed bench for conv_result_collector; a ReLU and a pass-through instance share stimulus.
module tb_conv_result_collector;
    import conv_result_collector_pkg::*;

    typedef logic [DATA_WIDTH-1:0] lanes_t [ARRAY_SIZE];

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [BUS_WIDTH-1:0]   bus;
    logic                   done, clr, ready;

    logic                   r_valid, r_last, r_busy, r_ovf;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [INDEX_WIDTH-1:0] r_index;
    logic                   p_valid, p_last, p_busy, p_ovf;
    logic [DATA_WIDTH-1:0]  p_data;
    logic [INDEX_WIDTH-1:0] p_index;

    int total = 0;
    int bad   = 0;

    lanes_t w1      = '{32'd10, 32'hFFFF_FFFB, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd3};
    lanes_t w1_relu = '{32'd10, 32'd0, 32'd7, 32'd0, 32'd0, 32'd3};

    conv_result_collector #(.RELU_EN(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_pixel_bus(bus),
        .i_done     (done),
        .i_clr_ovf  (clr),
        .i_ready    (ready),
        .o_valid    (r_valid),
        .o_data     (r_data),
        .o_index    (r_index),
        .o_last     (r_last),
        .o_busy     (r_busy),
        .o_overflow (r_ovf)
    );

    conv_result_collector #(.RELU_EN(1'b0)) dut_nr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_pixel_bus(bus),
        .i_done     (done),
        .i_clr_ovf  (clr),
        .i_ready    (ready),
        .o_valid    (p_valid),
        .o_data     (p_data),
        .o_index    (p_index),
        .o_last     (p_last),
        .o_busy     (p_busy),
        .o_overflow (p_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [BUS_WIDTH-1:0] pack(input lanes_t v);
        logic [BUS_WIDTH-1:0] b;
        b = '0;
        for (int i = 0; i < ARRAY_SIZE; i++) b[(ARRAY_SIZE-1-i)*DATA_WIDTH +: DATA_WIDTH] = v[i];
        return b;
    endfunction

    // Window w of the ordering tests carries lane l = 10*w + l + 1.
    function automatic logic [BUS_WIDTH-1:0] seq_bus(input int w);
        lanes_t v;
        for (int i = 0; i < ARRAY_SIZE; i++) v[i] = DATA_WIDTH'(10 * w + i + 1);
        return pack(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; done = 1'b0; clr = 1'b0; ready = 1'b1; bus = '0;
        tick();
        tick();
        total++;
        if ({r_valid, r_index, r_last, r_busy, r_ovf, r_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%0b i=%0d l=%0b b=%0b o=%0b d=%h, want all 0",
                     r_valid, r_index, r_last, r_busy, r_ovf, r_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    // Single window, ready high; covers ReLU and pass-through instances.
    task automatic test_single();
        int nb;
        nb = 0;
        bus = pack(w1);
        for (int e = 0; e <= 11; e++) begin
            done = (e == 0);
            tick();
            total++;
            if (r_valid !== (e >= 3 && e <= 8) || r_busy !== (e >= 3 && e <= 8)) begin
                bad++;
                $display("FAIL single_valid_busy edge %0d: got v=%0b b=%0b", e, r_valid, r_busy);
            end
            if (r_valid === 1'b1) begin
                total++;
                if (r_data !== w1_relu[nb] || r_index !== INDEX_WIDTH'(nb) ||
                    r_last !== (nb == 5)) begin
                    bad++;
                    $display("FAIL single_beat %0d: got d=%h i=%0d l=%0b, want d=%h i=%0d l=%0b",
                             nb, r_data, r_index, r_last, w1_relu[nb], nb, nb == 5);
                end
                total++;
                if (p_valid !== 1'b1 || p_data !== w1[nb]) begin
                    bad++;
                    $display("FAIL passthru_beat %0d: got v=%0b d=%h, want d=%h",
                             nb, p_valid, p_data, w1[nb]);
                end
                nb++;
            end
        end
        total++;
        if (nb != 6) begin
            bad++;
            $display("FAIL single_count: got %0d beats, want 6", nb);
        end
    endtask

    task automatic test_backpressure();
        int nb, last_e;
        nb = 0; last_e = -1;
        bus = pack(w1);
        for (int e = 0; e <= 16; e++) begin
            done  = (e == 0);
            ready = !(e >= 5 && e <= 7);
            if (e >= 5 && e <= 7) begin
                total++;
                if (r_valid !== 1'b1 || r_index !== 3'd1 || r_data !== w1_relu[1] ||
                    p_data !== w1[1]) begin
                    bad++;
                    $display("FAIL bp_hold edge %0d: got v=%0b i=%0d d=%h pd=%h, want i=1 pd=%h",
                             e, r_valid, r_index, r_data, p_data, w1[1]);
                end
            end
            if (r_valid === 1'b1 && ready) begin
                total++;
                if (nb > 5 || p_index !== INDEX_WIDTH'(nb) || p_data !== w1[nb]) begin
                    bad++;
                    $display("FAIL bp_beat %0d: got i=%0d d=%h", nb, p_index, p_data);
                end
                nb++;
                last_e = e;
            end
            tick();
        end
        ready = 1'b1;
        total++;
        if (nb != 6 || last_e != 12) begin
            bad++;
            $display("FAIL bp_summary: got beats=%0d last=%0d, want beats=6 last=12", nb, last_e);
        end
    endtask

    task automatic test_overflow();
        int nb;
        nb = 0;
        ready = 1'b0;
        for (int e = 0; e <= 8; e++) begin
            done = (e <= 2);
            bus  = (e <= 3) ? seq_bus(0) : (e == 4) ? seq_bus(1) : seq_bus(2);
            tick();
            total++;
            if (r_ovf !== (e >= 5)) begin
                bad++;
                $display("FAIL ovf_flag edge %0d: got %0b, want %0b", e, r_ovf, e >= 5);
            end
        end
        ready = 1'b1;
        for (int e = 0; e < 20; e++) begin
            if (r_valid === 1'b1) begin
                total++;
                if (nb >= 12 || r_data !== DATA_WIDTH'(10 * (nb / 6) + nb % 6 + 1) ||
                    r_last !== (nb % 6 == 5)) begin
                    bad++;
                    $display("FAIL ovf_drain beat %0d: got d=%0d l=%0b", nb, r_data, r_last);
                end
                nb++;
            end
            tick();
        end
        total++;
        if (nb != 12 || r_busy !== 1'b0 || r_ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_drain_total: got beats=%0d busy=%0b ovf=%0b, want 12 0 1",
                     nb, r_busy, r_ovf);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++;
        if (r_ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear: got %0b, want 0", r_ovf);
        end
    endtask

    // Third capture lands on the edge of the first window's o_last handshake.
    task automatic test_back_to_back();
        int nb, last_e;
        nb = 0; last_e = -1;
        ready = 1'b1;
        for (int e = 0; e <= 25; e++) begin
            done = (e == 0 || e == 1 || e == 6);
            bus  = (e <= 3) ? seq_bus(0) : (e == 4) ? seq_bus(1) : seq_bus(2);
            if (r_valid === 1'b1) begin
                total++;
                if (nb >= 18 || r_data !== DATA_WIDTH'(10 * (nb / 6) + nb % 6 + 1) ||
                    r_index !== INDEX_WIDTH'(nb % 6)) begin
                    bad++;
                    $display("FAIL b2b_beat %0d: got d=%0d i=%0d", nb, r_data, r_index);
                end
                nb++;
                last_e = e;
            end
            tick();
            total++;
            if (r_ovf !== 1'b0) begin
                bad++;
                $display("FAIL b2b_overflow edge %0d: got %0b, want 0", e, r_ovf);
            end
        end
        total++;
        if (nb != 18 || last_e != 21 || r_busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_total: got beats=%0d last=%0d busy=%0b, want 18 21 0",
                     nb, last_e, r_busy);
        end
    endtask

    task automatic test_reset_mid();
        ready = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            done = (e <= 1);
            bus  = (e <= 3) ? seq_bus(0) : seq_bus(1);
            tick();
        end
        total++;
        if (r_valid !== 1'b1 || r_index !== 3'd3) begin
            bad++;
            $display("FAIL rst_mid_setup: got v=%0b i=%0d, want v=1 i=3", r_valid, r_index);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({r_valid, r_busy, r_index, r_last, r_ovf, r_data} !== '0) begin
            bad++;
            $display("FAIL rst_mid_async: got v=%0b b=%0b i=%0d d=%h, want all 0",
                     r_valid, r_busy, r_index, r_data);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int e = 0; e < 12; e++) begin
            tick();
            total++;
            if (r_valid !== 1'b0 || r_busy !== 1'b0) begin
                bad++;
                $display("FAIL rst_mid_after cycle %0d: got v=%0b b=%0b, want 0 0",
                         e, r_valid, r_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        tick();
        test_backpressure();
        tick();
        test_overflow();
        tick();
        test_back_to_back();
        tick();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_result_collector.md
Name: conv_result_collector

Overview:
Downstream stage of the 6-wide convolution kernel array.
- Captures the parallel accumulator bus once per completed kernel window, at a fixed latency after the window's last tap.
- Buffers up to two captured windows in a 2-entry FIFO.
- Serialises each window's ARRAY_SIZE results onto a single valid/ready stream, with optional ReLU, for the pooling/output buffer stage.

Parameters:
- ARRAY_SIZE, 6, number of parallel kernels (lanes) on the input bus.
- DATA_WIDTH, 32, signed two's-complement width of each lane result.
- KERNEL_LATENCY, 3, cycles from last-tap input at the array to a valid accumulator output.
- RELU_EN, 1, 1 = negative lane values are output as 0; 0 = pass-through.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_pixel_bus  in  ARRAY_SIZE*DATA_WIDTH  accumulator bus from the kernel array; lane 0 = MS slice
- i_done  in  1  one-cycle strobe, aligned with the cycle the window's last tap enters the array
- i_clr_ovf  in  1  clears the sticky overflow flag
- i_ready  in  1  downstream ready
- o_valid  out  1  o_data valid
- o_data  out  DATA_WIDTH  current lane result (after optional ReLU)
- o_index  out  3  lane index of o_data, 0..ARRAY_SIZE-1
- o_last  out  1  high with the last lane (index ARRAY_SIZE-1) of a window
- o_busy  out  1  FIFO not empty or serialiser active
- o_overflow  out  1  sticky: a capture was dropped

Behaviour:
Clock and reset: clock clk; reset rst_n, asynchronous, active-low.

Reset:
- Delay line, FIFO count/pointers, lane index and FSM clear immediately.
- o_valid=0, o_index=0, o_last=0, o_busy=0, o_overflow=0, o_data=0.
- Reset mid-serialisation discards all buffered windows. No partial output after release.

Capture:
- i_done enters a KERNEL_LATENCY-deep shift register.
- If i_done is sampled at edge N, i_pixel_bus is written to the FIFO at edge N+KERNEL_LATENCY.
- Back-to-back i_done strobes (every cycle) are legal; each is captured independently.

FIFO:
- 2 entries, full-bus width; count 0..2.
- Capture when count<2: accepted.
- Capture when count==2 and a pop occurs at the same edge: accepted; count stays 2.
- Capture when count==2 and no pop at that edge: data dropped, o_overflow set at that edge.
- o_overflow stays set until i_clr_ovf is sampled high. If a set and a clear occur at the same edge, set wins.

Serialiser FSM:
- IDLE:
  - o_valid=0.
  - Go to SEND at the edge where count becomes non-zero.
  - o_valid rises in the cycle after the capture edge, so the first output is KERNEL_LATENCY+1 cycles after i_done.
- SEND:
  - o_valid=1; o_data = lane o_index of the FIFO head.
  - ReLU applied: if RELU_EN and sign bit set, o_data=0.
  - Handshake = o_valid & i_ready; o_index increments on each handshake.
  - On handshake with o_index==ARRAY_SIZE-1: pop head, reset o_index to 0. Stay in SEND if the remaining count >0, else go to IDLE.
- o_data, o_index and o_last hold stable while o_valid=1 and i_ready=0.
- o_valid never drops before its handshake completes.
- o_last = (o_index==ARRAY_SIZE-1) & o_valid.
- o_busy = (count!=0) | (state==SEND).

Arithmetic: no rescaling or saturation. Lane values pass through bit-exact, except for ReLU zeroing.

Decomposition:
Shared constants go in the existing conv kernel parameter include / global define:
- ARRAY_SIZE
- DATA_WIDTH (`DATA_WIDTH)
- KERNEL_LATENCY, defined once and used by both the kernel array's clear-delay logic and this block.

One sub-module: conv_result_fifo2, a 2-entry full-bus FIFO.
- Inputs: push, pop, data in.
- Outputs: head data, count, overflow-on-push-when-full.

The FSM, lane mux and ReLU stay in the top module.

Test Plan:
1. Single window, DATA_WIDTH=32, lanes = {10,-5,7,0,-1,3}, RELU_EN=1, i_ready=1; i_done pulsed at cycle 0.
   - Bus captured at edge 3.
   - o_valid high cycles 4..9 with o_data 10,0,7,0,0,3.
   - o_index 0..5; o_last only at cycle 9; o_busy low again after cycle 9.
2. Same stimulus with RELU_EN=0.
   - Outputs 10,-5,7,0,-1,3 bit-exact (-5 = 0xFFFFFFFB).
3. Backpressure: i_ready low at cycles 5..7 during scenario 1.
   - Lane 1 value and o_index=1 held stable cycles 5..7.
   - No duplicate or skipped lanes; all 6 lanes delivered; last handshake at cycle 12.
4. Overflow: i_ready=0, i_done pulsed at cycles 0, 1, 2.
   - Captures at edges 3 and 4 accepted; capture at edge 5 dropped.
   - o_overflow=1 from edge 5.
   - After i_ready=1, exactly 12 beats from windows 0 and 1.
   - i_clr_ovf pulse clears o_overflow.
5. Simultaneous pop and push when full: i_done timed so a capture lands on the same edge as the o_last handshake.
   - Capture accepted, o_overflow stays 0.
   - All three windows delivered in order.
6. Reset mid-operation: rst_n asserted at beat 3 of a window with a second window queued.
   - o_valid=0, o_busy=0 immediately.
   - After release with no i_done, o_valid stays 0.
